vga_text_console: RTL
=====================

VGA_TEXT_CONSOLE -- requirements
Module: vga_text_console

Interface
REQ-001 Parameter COLS, default 80: character columns per row.
REQ-002 Parameter ROWS, default 34: character rows per screen; COLS*ROWS (2720) is the char RAM depth.
REQ-003 clk25mhz  input  1  pixel clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  character byte offered.
REQ-006 in_char  input  8  byte; bit7 is the emphasis flag, bits[6:0] are the glyph or control code.
REQ-007 in_ready  output  1  block can accept a byte this cycle.
REQ-008 ram_addr  output  12  char RAM address, linear row*COLS+col.
REQ-009 ram_wdata  output  8  char RAM write data.
REQ-010 ram_we  output  1  char RAM write strobe.
REQ-011 ram_re  output  1  char RAM read strobe.
REQ-012 ram_rdata  input  8  char RAM read data, valid exactly 1 cycle after ram_re.
REQ-013 cursor_col  output  7  current column, 0..COLS-1.
REQ-014 cursor_row  output  6  current row, 0..ROWS-1.
REQ-015 busy  output  1  clear or scroll sequence in progress.

Function
REQ-016 All outputs SHALL be registered; in_ready SHALL equal (state==IDLE).
REQ-017 The FSM states SHALL be CLEAR, IDLE, WRITE, SCROLL_RD, SCROLL_WR, and FILL.
REQ-018 A byte SHALL be accepted only on a cycle with in_valid && in_ready.
- No internal buffering.
- in_char is sampled at acceptance.
REQ-019 Printable byte (in_char[6:0] >= 0x20):
- Next cycle is WRITE, with ram_we=1, ram_addr=cursor address, ram_wdata=in_char.
- The cursor then advances by one column.
REQ-020 Column wrap: col==COLS-1 advance SHALL set col=0 and row+1.
- If row==ROWS-1, row stays ROWS-1 and the FSM enters SCROLL_RD instead of IDLE.
REQ-021 0x0D (CR) SHALL set col=0, with no RAM write; the FSM returns to IDLE the next cycle.
REQ-022 0x0A (LF) SHALL set col=0 and row+1.
- At row ROWS-1 it starts a scroll; row stays ROWS-1.
REQ-023 0x08 (BS) with col>0 SHALL set col-1 and write 0x20 at the new address.
- With col==0 it is a no-op: the row does not change and there is no write.
REQ-024 0x0C (FF) SHALL enter CLEAR and reset the cursor to (0,0).
REQ-025 Any other control code (<0x20) SHALL be discarded with no state change beyond a one-cycle return to IDLE.
REQ-026 CLEAR SHALL write 0x20 to addresses 0..COLS*ROWS-1, one per cycle, in ascending order, then go to IDLE.
- Duration: 2720 cycles.
REQ-027 Scroll: for src=COLS..COLS*ROWS-1 in ascending order:
- SCROLL_RD asserts ram_re with ram_addr=src.
- SCROLL_WR asserts ram_we with ram_addr=src-COLS and ram_wdata=ram_rdata.
- This is 2 cycles per character and 5280 cycles total.
REQ-028 FILL SHALL then write 0x20 to the last row (addresses 2640..2719), one per cycle, then go to IDLE.
REQ-029 The ram_we and ram_re strobes SHALL never be asserted in the same cycle.
- Outside the cycles defined above, both strobes SHALL be 0.
REQ-030 busy SHALL be 1 in CLEAR, SCROLL_RD, SCROLL_WR and FILL, and 0 otherwise.
REQ-031 The cursor SHALL not change during CLEAR/SCROLL/FILL, except the reset to (0,0) by FF.
REQ-032 Address arithmetic SHALL be 12-bit unsigned; the cursor address SHALL never exceed COLS*ROWS-1.

Reset
REQ-033 While rst_n=0, outputs SHALL be: ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, cursor=(0,0), in_ready=0, busy=1.
REQ-034 After rst_n deasserts, the FSM SHALL enter CLEAR on the first clock edge.
REQ-035 Reset asserted mid-scroll or mid-clear SHALL abort immediately; the full CLEAR restarts after release.

Verification
REQ-036 Release reset:
- Expect 2720 writes of 0x20 at addresses 0..2719, one per cycle.
- Then in_ready=1, busy=0.
REQ-037 Accept 0x41 at cursor (0,0):
- Next cycle shows ram_we=1, addr=0, wdata=0x41.
- Then cursor=(1,0).
REQ-038 Accept 0xC1 at (79,5):
- Write at addr 479 with wdata 0xC1.
- Cursor becomes (0,6); no scroll.
REQ-039 Preload distinct row data; accept 0x0A at row 33:
- Each addr a (0..2639) receives the prior content of a+80.
- Addresses 2640..2719 receive 0x20; busy lasts 5360 cycles.
- Cursor ends at (0,33).
REQ-040 BS and CR boundaries:
- BS at (0,7): no write, cursor unchanged.
- BS at (3,7): write 0x20 at addr 562, cursor (2,7).
- CR at (40,2): cursor (0,2), no write.
REQ-041 Assert rst_n=0 during scroll cycle 1000:
- Strobes drop immediately.
- After release, the full CLEAR replays and the cursor is (0,0).

Source files
------------

// File: rtl/vga_text_console_if.sv
// ---------------------------------------------------------------------------
// vga_text_console_if
// Bundles the byte-input handshake and the character-RAM port of the text
// console so they travel as one port.
//   in_valid / in_char / in_ready        : byte offer and acceptance
//   ram_addr / ram_wdata / ram_we /
//   ram_re / ram_rdata                   : character RAM access
// Modports:
//   slave  - the console (consumes bytes, drives the RAM port)
//   master - the environment (offers bytes, serves RAM reads)
// ---------------------------------------------------------------------------
interface vga_text_console_if;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_rdata;

    modport slave (
        input  in_valid, in_char, ram_rdata,
        output in_ready, ram_addr, ram_wdata, ram_we, ram_re
    );

    modport master (
        output in_valid, in_char, ram_rdata,
        input  in_ready, ram_addr, ram_wdata, ram_we, ram_re
    );
endinterface

// File: rtl/vga_text_console.sv
// ---------------------------------------------------------------------------
// vga_text_console
// Teletype-style text console writing into an external character RAM laid
// out linearly as row*COLS+col. Printable bytes are written at the cursor,
// CR/LF/BS/FF are interpreted, the screen scrolls up one row when a line
// feed or wrap happens on the last row, and the whole screen is blanked
// after reset and on form feed.
// Ports:
//   clk25mhz    pixel clock, everything on its rising edge
//   rst_n       asynchronous active-low reset
//   bus         vga_text_console_if.slave (byte handshake + RAM port)
//   cursor_col  current cursor column
//   cursor_row  current cursor row
//   busy        clear / scroll / fill sequence in progress
// ---------------------------------------------------------------------------
module vga_text_console #(
    parameter int COLS = 80,
    parameter int ROWS = 34
) (
    input  logic                 clk25mhz,
    input  logic                 rst_n,
    vga_text_console_if.slave    bus,
    output logic [6:0]           cursor_col,
    output logic [5:0]           cursor_row,
    output logic                 busy
);

    localparam logic [11:0] COLS_W        = 12'(COLS);
    localparam logic [11:0] LAST_ADDR     = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_ROW_BASE = 12'(COLS * (ROWS - 1));
    localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW      = 6'(ROWS - 1);
    localparam logic [7:0]  SPACE         = 8'h20;
    localparam logic [6:0]  CODE_BS       = 7'h08;
    localparam logic [6:0]  CODE_LF       = 7'h0A;
    localparam logic [6:0]  CODE_FF       = 7'h0C;
    localparam logic [6:0]  CODE_CR       = 7'h0D;

    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        IDLE      = 3'd1,
        WRITE     = 3'd2,
        SCROLL_RD = 3'd3,
        SCROLL_WR = 3'd4,
        FILL      = 3'd5
    } state_t;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20);
    endfunction

    state_t      state_r, state_n;
    logic [11:0] idx_r, idx_n;       // running address of clear / scroll source / fill
    logic [11:0] addr_r, addr_n;
    logic [7:0]  wdata_r, wdata_n;
    logic        we_r, we_n;
    logic        re_r, re_n;
    logic        wsel_r, wsel_n;     // 1 while ram_wdata forwards ram_rdata
    logic        in_ready_r, in_ready_n;
    logic        busy_r, busy_n;
    logic [6:0]  col_r, col_n;
    logic [5:0]  row_r, row_n;
    logic [6:0]  char_r, char_n;     // code accepted in IDLE, interpreted in WRITE
    logic        newline_s;
    logic [11:0] cur_addr_s;

    assign cur_addr_s = ({6'd0, row_r} * COLS_W) + {5'd0, col_r};

    // Next state, next cursor and next registered RAM strobes/address/data.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        addr_n    = addr_r;
        wdata_n   = wdata_r;
        we_n      = 1'b0;
        re_n      = 1'b0;
        col_n     = col_r;
        row_n     = row_r;
        char_n    = char_r;
        newline_s = 1'b0;

        case (state_r)
            CLEAR: begin
                // idx_r leaves reset as all ones so the first step lands on 0.
                if (idx_r == LAST_ADDR) begin
                    state_n = IDLE;
                end else begin
                    idx_n   = idx_r + 12'd1;
                    we_n    = 1'b1;
                    addr_n  = idx_r + 12'd1;
                    wdata_n = SPACE;
                end
            end

            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    state_n = WRITE;
                    char_n  = bus.in_char[6:0];
                    if (is_printable(bus.in_char[6:0])) begin
                        we_n    = 1'b1;
                        addr_n  = cur_addr_s;
                        wdata_n = bus.in_char;
                    end else if ((bus.in_char[6:0] == CODE_BS) && (col_r != 7'd0)) begin
                        // Backspace blanks the cell the cursor is about to move onto.
                        we_n    = 1'b1;
                        addr_n  = cur_addr_s - 12'd1;
                        wdata_n = SPACE;
                    end else begin
                        we_n = 1'b0;
                    end
                end else begin
                    state_n = IDLE;
                end
            end

            WRITE: begin
                state_n = IDLE;
                if (is_printable(char_r)) begin
                    if (col_r == LAST_COL) begin
                        col_n     = 7'd0;
                        newline_s = 1'b1;
                    end else begin
                        col_n = col_r + 7'd1;
                    end
                end else begin
                    case (char_r)
                        CODE_CR: col_n = 7'd0;
                        CODE_LF: begin
                            col_n     = 7'd0;
                            newline_s = 1'b1;
                        end
                        CODE_BS: begin
                            if (col_r != 7'd0) begin
                                col_n = col_r - 7'd1;
                            end else begin
                                col_n = col_r;
                            end
                        end
                        CODE_FF: begin
                            col_n   = 7'd0;
                            row_n   = 6'd0;
                            state_n = CLEAR;
                            idx_n   = 12'd0;
                            we_n    = 1'b1;
                            addr_n  = 12'd0;
                            wdata_n = SPACE;
                        end
                        default: col_n = col_r;
                    endcase
                end
                // A new line on the bottom row keeps the row and scrolls instead.
                if (newline_s) begin
                    if (row_r == LAST_ROW) begin
                        state_n = SCROLL_RD;
                        idx_n   = COLS_W;
                        re_n    = 1'b1;
                        addr_n  = COLS_W;
                    end else begin
                        row_n = row_r + 6'd1;
                    end
                end else begin
                    row_n = row_n;
                end
            end

            SCROLL_RD: begin
                // Data read this cycle is forwarded as write data next cycle.
                state_n = SCROLL_WR;
                we_n    = 1'b1;
                addr_n  = idx_r - COLS_W;
            end

            SCROLL_WR: begin
                if (idx_r == LAST_ADDR) begin
                    state_n = FILL;
                    idx_n   = LAST_ROW_BASE;
                    we_n    = 1'b1;
                    addr_n  = LAST_ROW_BASE;
                    wdata_n = SPACE;
                end else begin
                    state_n = SCROLL_RD;
                    idx_n   = idx_r + 12'd1;
                    re_n    = 1'b1;
                    addr_n  = idx_r + 12'd1;
                end
            end

            FILL: begin
                if (idx_r == LAST_ADDR) begin
                    state_n = IDLE;
                end else begin
                    idx_n   = idx_r + 12'd1;
                    we_n    = 1'b1;
                    addr_n  = idx_r + 12'd1;
                    wdata_n = SPACE;
                end
            end

            default: begin
                state_n = CLEAR;
                idx_n   = 12'hFFF;
                col_n   = 7'd0;
                row_n   = 6'd0;
            end
        endcase

        wsel_n     = (state_n == SCROLL_WR);
        in_ready_n = (state_n == IDLE);
        busy_n     = (state_n == CLEAR) || (state_n == SCROLL_RD) ||
                     (state_n == SCROLL_WR) || (state_n == FILL);
    end

    // State, cursor and output registers.
    always_ff @(posedge clk25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= CLEAR;
            idx_r      <= 12'hFFF;
            addr_r     <= 12'd0;
            wdata_r    <= 8'd0;
            we_r       <= 1'b0;
            re_r       <= 1'b0;
            wsel_r     <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            col_r      <= 7'd0;
            row_r      <= 6'd0;
            char_r     <= 7'd0;
        end else begin
            state_r    <= state_n;
            idx_r      <= idx_n;
            addr_r     <= addr_n;
            wdata_r    <= wdata_n;
            we_r       <= we_n;
            re_r       <= re_n;
            wsel_r     <= wsel_n;
            in_ready_r <= in_ready_n;
            busy_r     <= busy_n;
            col_r      <= col_n;
            row_r      <= row_n;
            char_r     <= char_n;
        end
    end

    // The scroll copy runs at two cycles per character, so the write data of
    // SCROLL_WR is the RAM's own (registered) read data passed straight on;
    // the select itself is a register.
    assign bus.ram_wdata = wsel_r ? bus.ram_rdata : wdata_r;
    assign bus.ram_addr  = addr_r;
    assign bus.ram_we    = we_r;
    assign bus.ram_re    = re_r;
    assign bus.in_ready  = in_ready_r;
    assign cursor_col    = col_r;
    assign cursor_row    = row_r;
    assign busy          = busy_r;

endmodule
